fpnew_writeback_buffer: RTL and testbench
=========================================

# fpnew_writeback_buffer

Result-side companion to the FPU operation-group/top datapath: terminates the FPU output handshake (`result`, `status`, `ext_bit`, `tag`, `out_valid`/`out_ready`) and presents results to the core in order of arrival. It buffers results in a small FIFO and limits the FPU to a fixed number of operations in flight through a credit counter. It also keeps the sticky exception flags (fflags) and updates them only when a result retires to the core, so flushed results never set flags.

## Interface
- `Width`, 32: result width, equal to the FPU `Width`.
- `Depth`, 4: FIFO entries and issue credits. Must be a power of two, ≥ 2.
- `TagType`, logic: tag type passed through from the FPU.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: synchronous flush of buffered and in-flight state.
- `issue_fire_i`  in  1: the core handed one operation to the FPU this cycle (FPU `in_valid & in_ready`).
- `credit_avail_o`  out  1: another operation may be issued.
- `fpu_result_i`  in  Width: FPU result.
- `fpu_status_i`  in  5 (`fpnew_pkg::status_t`): {NV, DZ, OF, UF, NX}.
- `fpu_ext_bit_i`  in  1: FPU extension bit.
- `fpu_tag_i`  in  TagType: FPU tag.
- `fpu_out_valid_i`  in  1: FPU result valid.
- `fpu_out_ready_o`  out  1: buffer accepts a result.
- `wb_result_o`  out  Width: result to the core.
- `wb_status_o`  out  5: status to the core.
- `wb_ext_bit_o`  out  1: extension bit to the core.
- `wb_tag_o`  out  TagType: tag to the core.
- `wb_valid_o`  out  1: head entry is valid.
- `wb_ready_i`  in  1: core takes the head entry.
- `fflags_clr_i`  in  1: clear the sticky flags.
- `fflags_o`  out  5: sticky accumulated flags.
- `busy_o`  out  1: operations are outstanding (in flight or buffered).

## Operation
- **FIFO storage:** Depth entries of {result, status, ext_bit, tag}. Read and write pointers have width log2(Depth) and wrap modulo Depth. The count register is log2(Depth)+1 bits, range 0..Depth.
- **Push:** on `fpu_out_valid_i & fpu_out_ready_o`. `fpu_out_ready_o = (count != Depth)`. It depends only on registered state; there is no combinational path from `wb_ready_i`.
- **Pop:** on `wb_valid_o & wb_ready_i`. `wb_valid_o = (count != 0)`. The `wb_*` data outputs come straight from the head entry. While empty they are don't-care but must not be X after reset (storage is reset to 0).
- **Push and pop in the same cycle:** allowed when 0 < count < Depth. Count is unchanged and both pointers advance.
- **Outstanding counter:** 0..Depth.
  - Increments on `issue_fire_i`.
  - Decrements on pop.
  - Unchanged when both happen in the same cycle.
  - `credit_avail_o = (outstanding != Depth)`.
  - `busy_o = (outstanding != 0)`.
  - Because outstanding ≥ count, the FIFO can never overflow while credits are respected.
- **Protocol violations:** `issue_fire_i` while `credit_avail_o` = 0 is a violation and is flagged by an assertion. A decrement at outstanding = 0 cannot occur and is asserted against.
- **fflags:**
  - Next value = (`fflags_clr_i` ? 0 : `fflags_o`) | (pop ? head status : 0).
  - When clear and pop coincide, the popped status survives.
  - Push alone never changes the flags.
- **Flush:**
  - Count, pointers and outstanding go to 0 in the next cycle.
  - In the flush cycle, pushes, pops and `issue_fire_i` are ignored.
  - fflags keep their value, except that `fflags_clr_i` is still honoured in the flush cycle.
  - `wb_valid_o` may be 1 during the flush cycle. The core must treat a handshake in that cycle as discarded, and no flag accumulates.

## Timing
- **Reset values (all outputs):** `wb_valid_o`=0, `busy_o`=0, `fflags_o`=0, `credit_avail_o`=1, `fpu_out_ready_o`=1, `wb_result_o`/`wb_status_o`/`wb_ext_bit_o`/`wb_tag_o` = 0.
- **Latency:** an FPU result accepted in cycle N gives `wb_valid_o`=1 in cycle N+1. There is no fall-through path.
- **Full FIFO:** `fpu_out_ready_o` stays 0 for the whole cycle, even if a pop happens in that cycle. It rises in the cycle after the pop.
- **Credit return:** a pop in cycle N raises `credit_avail_o` in cycle N+1 (registered counter).
- **Flag update:** `fflags_o` reflects a pop in cycle N from cycle N+1.
- **Reset during operation:** all state clears immediately (asynchronous). Data in flight is lost.

## Test plan
- **Single op:** issue 1 → FPU returns result 0x3F800000, status NX, tag 1 in cycle 3, with `wb_ready_i`=1 → `wb_valid_o` in cycle 4 with the same data; `fflags_o`=NX in cycle 5; `busy_o` falls in cycle 5.
- **Credit exhaustion:** Depth=4, issue 4 back-to-back with no pops → `credit_avail_o`=0 after the 4th issue. Push 4 results → `fpu_out_ready_o`=0. Pop 1 → `credit_avail_o` and `fpu_out_ready_o` return to 1 in the next cycle.
- **Ordering and wrap:** stream 10 results with tags 0..9 under random `wb_ready_i` stalls → the core sees 0..9 in order, with no loss or duplication across pointer wrap.
- **Flag timing:** push a result with DZ, hold `wb_ready_i`=0 for 5 cycles → `fflags_o`=0 throughout. Then pop with `fflags_clr_i`=1 in the same cycle → `fflags_o`=DZ.
- **Flush:** 3 results buffered with NV set, `fflags_o`=OF; assert `flush_i` → the next cycle has `wb_valid_o`=0, `busy_o`=0, `credit_avail_o`=1, `fflags_o`=OF (NV never appears).
- **Simultaneous push/pop at count=2:** count stays 2, both pointers advance, head data is correct.

Source files
------------

// File: rtl/fpnew_writeback_buffer.sv
// Result-side buffer for the FPU: in-order FIFO of results, issue credit counter and
// sticky fflags that accumulate only when a result retires to the core.
module fpnew_writeback_buffer #(
   parameter int unsigned Width   = 32,
   parameter int unsigned Depth   = 4,
   parameter type         TagType = logic
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             issue_fire_i,
   output logic             credit_avail_o,
   input  logic [Width-1:0] fpu_result_i,
   input  logic [4:0]       fpu_status_i,
   input  logic             fpu_ext_bit_i,
   input  TagType           fpu_tag_i,
   input  logic             fpu_out_valid_i,
   output logic             fpu_out_ready_o,
   output logic [Width-1:0] wb_result_o,
   output logic [4:0]       wb_status_o,
   output logic             wb_ext_bit_o,
   output TagType           wb_tag_o,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   input  logic             fflags_clr_i,
   output logic [4:0]       fflags_o,
   output logic             busy_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] result_q [Depth];
   logic [4:0]       status_q [Depth];
   logic             ext_q    [Depth];
   TagType           tag_q    [Depth];

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;
   logic [PtrW:0]   outst_q, outst_d;
   logic [4:0]      fflags_q, fflags_d;
   logic            push, pop, issue;

   assign fpu_out_ready_o = (count_q != DepthCnt);
   assign wb_valid_o      = (count_q != '0);
   assign credit_avail_o  = (outst_q != DepthCnt);
   assign busy_o          = (outst_q != '0);
   assign fflags_o        = fflags_q;

   assign wb_result_o  = result_q[rd_ptr_q];
   assign wb_status_o  = status_q[rd_ptr_q];
   assign wb_ext_bit_o = ext_q[rd_ptr_q];
   assign wb_tag_o     = tag_q[rd_ptr_q];

   // A handshake during flush is discarded on both sides.
   assign push  = fpu_out_valid_i & fpu_out_ready_o & ~flush_i;
   assign pop   = wb_valid_o & wb_ready_i & ~flush_i;
   assign issue = issue_fire_i & ~flush_i;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      outst_d = outst_q;
      unique case ({issue, pop})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
      // Clear and retire in the same cycle keeps the retired status.
      fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (pop ? wb_status_o : 5'b0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         outst_q  <= '0;
         fflags_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         outst_q  <= '0;
         fflags_q <= fflags_clr_i ? 5'b0 : fflags_q;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         outst_q  <= outst_d;
         fflags_q <= fflags_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            result_q[i] <= '0;
            status_q[i] <= '0;
            ext_q[i]    <= 1'b0;
            tag_q[i]    <= '0;
         end
      end else if (push) begin
         result_q[wr_ptr_q] <= fpu_result_i;
         status_q[wr_ptr_q] <= fpu_status_i;
         ext_q[wr_ptr_q]    <= fpu_ext_bit_i;
         tag_q[wr_ptr_q]    <= fpu_tag_i;
      end
   end

   issue_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      !(issue_fire_i && !credit_avail_o));
   retire_with_nothing_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop && !issue && outst_q == '0));

endmodule

// File: tb/tb_fpnew_writeback_buffer.sv
// Directed bench for fpnew_writeback_buffer (Width 32, Depth 4, 4-bit tag).
module tb_fpnew_writeback_buffer;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush, issue, fpu_valid, wb_ready, fclr;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_status;
   logic        fpu_ext;
   logic [3:0]  fpu_tag;
   logic        credit, fpu_ready, wb_valid, wb_ext, busy;
   logic [31:0] wb_result;
   logic [4:0]  wb_status, fflags;
   logic [3:0]  wb_tag;

   int nvec = 0;
   int nerr = 0;

   localparam logic [4:0] NV = 5'b10000, DZ = 5'b01000, OF = 5'b00100, NX = 5'b00001;

   always #5 clk = ~clk;

   fpnew_writeback_buffer #(.Width(32), .Depth(4), .TagType(logic [3:0])) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .issue_fire_i(issue),
      .credit_avail_o(credit), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
      .fpu_ext_bit_i(fpu_ext), .fpu_tag_i(fpu_tag), .fpu_out_valid_i(fpu_valid),
      .fpu_out_ready_o(fpu_ready), .wb_result_o(wb_result), .wb_status_o(wb_status),
      .wb_ext_bit_o(wb_ext), .wb_tag_o(wb_tag), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
      .fflags_clr_i(fclr), .fflags_o(fflags), .busy_o(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fpu_drive(input logic [31:0] r, input logic [4:0] s, input logic [3:0] t);
      fpu_valid = 1'b1; fpu_result = r; fpu_status = s; fpu_tag = t; fpu_ext = 1'b0;
   endtask

   initial begin
      int issued, returned, popped, budget;
      rst_ni = 1'b0; flush = 0; issue = 0; fpu_valid = 0; wb_ready = 0; fclr = 0;
      fpu_result = '0; fpu_status = '0; fpu_ext = 0; fpu_tag = '0;
      tick(); tick();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fflags", fflags, 0);
      chk("rst_credit", credit, 1);
      chk("rst_fpu_ready", fpu_ready, 1);
      chk("rst_wb_result", wb_result, 0);
      chk("rst_wb_tag", wb_tag, 0);
      rst_ni = 1'b1;
      tick();

      // Single op
      issue = 1; tick(); issue = 0;
      chk("single_busy", busy, 1);
      tick();
      fpu_valid = 1; fpu_result = 32'h3F800000; fpu_status = NX; fpu_tag = 4'd1; fpu_ext = 1;
      wb_ready = 1;
      chk("single_no_fallthrough", wb_valid, 0);
      tick(); fpu_valid = 0;
      chk("single_wb_valid", wb_valid, 1);
      chk("single_result", wb_result, 32'h3F800000);
      chk("single_status", wb_status, NX);
      chk("single_tag", wb_tag, 1);
      chk("single_ext", wb_ext, 1);
      chk("single_fflags_before", fflags, 0);
      tick(); wb_ready = 0;
      chk("single_fflags_after", fflags, NX);
      chk("single_busy_fall", busy, 0);
      chk("single_empty", wb_valid, 0);
      fclr = 1; tick(); fclr = 0;
      chk("clear_fflags", fflags, 0);

      // Credit exhaustion
      issue = 1;
      for (int i = 0; i < 4; i++) tick();
      issue = 0;
      chk("credit_exhausted", credit, 0);
      for (int i = 0; i < 4; i++) begin
         fpu_drive(32'h100 + i, 5'b0, 4'(i));
         tick();
      end
      fpu_valid = 0;
      chk("full_ready_low", fpu_ready, 0);
      chk("full_head", wb_result, 32'h100);
      wb_ready = 1;
      chk("full_ready_low_in_pop_cycle", fpu_ready, 0);
      tick(); wb_ready = 0;
      chk("credit_returned", credit, 1);
      chk("ready_returned", fpu_ready, 1);
      chk("head_after_pop", wb_result, 32'h101);
      wb_ready = 1; tick(); tick(); tick(); wb_ready = 0;
      chk("drained_valid", wb_valid, 0);
      chk("drained_busy", busy, 0);

      // Ordering and wrap under random stalls
      issued = 0; returned = 0; popped = 0; budget = 0;
      while (popped < 10 && budget < 300) begin
         issue = (issued < 10) && credit;
         if (returned < issued) fpu_drive(32'h200 + returned, 5'b0, 4'(returned));
         else fpu_valid = 0;
         wb_ready = 1'($urandom_range(0, 1));
         if (wb_valid && wb_ready) begin
            chk("order_tag", wb_tag, popped);
            chk("order_result", wb_result, 32'h200 + popped);
            popped++;
         end
         if (fpu_valid && fpu_ready) returned++;
         if (issue) issued++;
         tick();
         budget++;
      end
      issue = 0; fpu_valid = 0; wb_ready = 0;
      chk("order_all_seen", popped, 10);
      chk("order_idle", busy, 0);

      // Flag timing
      issue = 1; tick(); issue = 0;
      fpu_drive(32'h5, DZ, 4'd5); tick(); fpu_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("dz_held_fflags", fflags, 0);
         tick();
      end
      wb_ready = 1; fclr = 1; tick(); wb_ready = 0; fclr = 0;
      chk("dz_clear_and_pop", fflags, DZ);
      fclr = 1; tick(); fclr = 0;

      // Flush
      issue = 1; tick(); issue = 0;
      fpu_drive(32'h6, OF, 4'd6); tick(); fpu_valid = 0;
      wb_ready = 1; tick(); wb_ready = 0;
      chk("flush_pre_fflags", fflags, OF);
      issue = 1; tick(); tick(); tick(); issue = 0;
      for (int i = 0; i < 3; i++) begin
         fpu_drive(32'h7 + i, NV, 4'(7 + i));
         tick();
      end
      fpu_valid = 0;
      chk("flush_pre_valid", wb_valid, 1);
      flush = 1; wb_ready = 1; tick(); flush = 0; wb_ready = 0;
      chk("flush_valid", wb_valid, 0);
      chk("flush_busy", busy, 0);
      chk("flush_credit", credit, 1);
      chk("flush_fflags", fflags, OF);
      tick();
      chk("flush_fflags_later", fflags, OF);

      // Simultaneous push/pop at count 2
      issue = 1; tick(); tick(); tick(); issue = 0;
      fpu_drive(32'hA, 5'b0, 4'd1); tick();
      fpu_drive(32'hB, 5'b0, 4'd2); tick();
      fpu_drive(32'hC, 5'b0, 4'd3); wb_ready = 1;
      chk("pp_head_a", wb_result, 32'hA);
      tick(); fpu_valid = 0;
      chk("pp_head_b", wb_result, 32'hB);
      chk("pp_tag_b", wb_tag, 2);
      chk("pp_ready", fpu_ready, 1);
      tick();
      chk("pp_head_c", wb_result, 32'hC);
      chk("pp_still_valid", wb_valid, 1);
      tick(); wb_ready = 0;
      chk("pp_empty", wb_valid, 0);
      chk("pp_idle", busy, 0);

      // Asynchronous reset mid-operation
      issue = 1; tick(); issue = 0;
      fpu_drive(32'hD, NV, 4'd4); tick(); fpu_valid = 0;
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_valid", wb_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_fflags", fflags, 0);
      chk("async_rst_result", wb_result, 0);
      tick(); rst_ni = 1'b1; tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
